// File: rtl/fetch_stage.sv
// IF stage and IF/ID latch: PC sequencing, I-cache handshake,
// stall skid buffer, redirect discard and flush bubbles.
`ifndef OPCODE_FLUSH
`define OPCODE_FLUSH 4'hF
`endif

module fetch_stage #(
  parameter int              WORD     = 16,
  parameter logic [WORD-1:0] RESET_PC = 16'h0000,
  parameter logic [WORD-1:0] BUBBLE   = {`OPCODE_FLUSH, 12'h000}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_ready,
  input  logic [WORD-1:0] i_data,
  output logic            i_readC,
  output logic            i_writeC,
  output logic [WORD-1:0] i_address,
  input  logic            IFIDWrite,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  input  logic            halt,
  output logic [WORD-1:0] inst_ID,
  output logic [3:0]      opcode,
  output logic [5:0]      func_code,
  output logic [WORD-1:0] pc_ID,
  output logic [WORD-1:0] npc_ID,
  output logic [WORD-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t          r_state, w_state;
  logic [WORD-1:0] r_pc, w_pc;
  logic [WORD-1:0] r_inst, w_inst;
  logic [WORD-1:0] r_pc_id, w_pc_id;
  logic [WORD-1:0] r_npc_id, w_npc_id;
  logic [WORD-1:0] r_cnt, w_cnt;
  logic [WORD-1:0] r_skid, w_skid;
  logic [WORD-1:0] r_target, w_target;
  logic [WORD-1:0] w_pc_inc;
  logic [WORD-1:0] w_cnt_inc;

  assign w_pc_inc  = r_pc + 1'b1;
  assign w_cnt_inc = r_cnt + 1'b1;

  assign i_writeC    = 1'b0;
  assign i_address   = r_pc;
  assign inst_ID     = r_inst;
  assign opcode      = r_inst[WORD-1 -: 4];
  assign func_code   = r_inst[5:0];
  assign pc_ID       = r_pc_id;
  assign npc_ID      = r_npc_id;
  assign fetch_count = r_cnt;

  // Request only in FETCH/DISCARD; a halt or reset abandons the read at once.
  assign i_readC = ((r_state == S_FETCH) || (r_state == S_DISCARD))
                   && !halt && !reset;

  // State and IF/ID register update; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_inst   <= BUBBLE;
      r_pc_id  <= '0;
      r_npc_id <= '0;
      r_cnt    <= '0;
      r_skid   <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_inst   <= w_inst;
      r_pc_id  <= w_pc_id;
      r_npc_id <= w_npc_id;
      r_cnt    <= w_cnt;
      r_skid   <= w_skid;
      r_target <= w_target;
    end
  end

  // Next-state and next-register values; halt > redirect > normal flow.
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_inst   = r_inst;
    w_pc_id  = r_pc_id;
    w_npc_id = r_npc_id;
    w_cnt    = r_cnt;
    w_skid   = r_skid;
    w_target = r_target;
    if (halt) begin
      w_state = S_HALT;
      w_inst  = BUBBLE;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (redirect) begin
            w_inst = BUBBLE;
            if (i_ready) begin
              w_pc = redirect_pc;
            end else begin
              w_target = redirect_pc;
              w_state  = S_DISCARD;
            end
          end else if (i_ready) begin
            if (IFIDWrite) begin
              w_inst   = i_data;
              w_pc_id  = r_pc;
              w_npc_id = w_pc_inc;
              w_pc     = w_pc_inc;
              w_cnt    = w_cnt_inc;
            end else begin
              w_skid  = i_data;
              w_state = S_HOLD;
            end
          end else if (IFIDWrite) begin
            w_inst = BUBBLE;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            w_inst  = BUBBLE;
            w_pc    = redirect_pc;
            w_state = S_FETCH;
          end else if (IFIDWrite) begin
            w_inst   = r_skid;
            w_pc_id  = r_pc;
            w_npc_id = w_pc_inc;
            w_pc     = w_pc_inc;
            w_cnt    = w_cnt_inc;
            w_state  = S_FETCH;
          end
        end
        S_DISCARD: begin
          w_inst = BUBBLE;
          if (redirect) w_target = redirect_pc;
          if (i_ready) begin
            w_pc    = redirect ? redirect_pc : r_target;
            w_state = S_FETCH;
          end
        end
        S_HALT: begin
          w_inst = BUBBLE;
        end
        default: begin
          w_state = S_FETCH;
        end
      endcase
    end
  end

endmodule
